// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle control path: sequencer states, opcodes and branch funct3.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        FETCH     = 3'b000,
        DECODE    = 3'b001,
        EXECUTE   = 3'b010,
        MEMORY    = 3'b011,
        WRITEBACK = 3'b100,
        HALT      = 3'b101,
        RSV_6     = 3'b110,
        RSV_7     = 3'b111
    } estado_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_NOP,
        CL_ZERO
    } classe_t;

    // An all-zero word stops the machine; any unknown nonzero opcode is a NOP.
    function automatic classe_t classifica(input logic [XLEN-1:0] instr);
        classe_t c;
        case (instr[6:0])
            OP_R, OP_I: c = CL_ALU;
            OP_LOAD:    c = CL_LOAD;
            OP_STORE:   c = CL_STORE;
            OP_BRANCH:  c = CL_BRANCH;
            default:    c = (instr == '0) ? CL_ZERO : CL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/unidade_controle_pc_if.sv
// Control/PC unit bus: instruction and ALU flag in, sequencer state and datapath enables out.
interface unidade_controle_pc_if;
    import riscv_pkg::*;

    logic [XLEN-1:0] instrucao;
    logic            alu_zero;
    logic [XLEN-1:0] pc;
    logic [2:0]      estado;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            pc_write;
    logic            halted;
    logic [XLEN-1:0] instr_count;

    modport master (
        input  instrucao, alu_zero,
        output pc, estado, reg_write, mem_read, mem_write, pc_write, halted, instr_count
    );

    modport slave (
        output instrucao, alu_zero,
        input  pc, estado, reg_write, mem_read, mem_write, pc_write, halted, instr_count
    );
endinterface

// File: rtl/gera_imediato_b.sv
// B-type immediate: byte offset rebuilt from the scattered instruction fields, sign-extended.
module gera_imediato_b
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm
);

    assign imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

    // Remaining fields belong to other immediate formats.
    logic unused_campos;
    assign unused_campos = ^{instr[24:12], instr[6:0]};

endmodule

// File: rtl/unidade_controle_pc.sv
// Multi-cycle sequencer owning the PC and retire counter; drives fetch timing and datapath enables.
module unidade_controle_pc
    import riscv_pkg::*;
#(
    parameter int unsigned PC_LIMIT = 11
) (
    input  logic                     clk,
    input  logic                     reset_n,
    unidade_controle_pc_if.master    bus
);

    estado_t         state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] imm_b;
    logic signed [XLEN-1:0] desloc;
    logic [2:0]      funct3;
    classe_t         classe;
    logic            taken;
    logic            final_c;
    logic            reg_write_c, mem_read_c, mem_write_c, pc_write_c, halted_c;

    gera_imediato_b u_imm_b (
        .instr (bus.instrucao),
        .imm   (imm_b)
    );

    assign classe = classifica(bus.instrucao);
    assign funct3 = bus.instrucao[14:12];
    // Byte offset to word offset; bit 1 of the immediate is dropped.
    assign desloc = $signed(imm_b) >>> 2;
    assign taken  = ((funct3 == F3_BEQ) &&  bus.alu_zero) ||
                    ((funct3 == F3_BNE) && !bus.alu_zero);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, PC update and Moore enables.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        next_pc     = pc_q + XLEN'(1);
        final_c     = 1'b0;
        reg_write_c = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        pc_write_c  = 1'b0;
        halted_c    = 1'b0;

        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                case (classe)
                    CL_ZERO: state_d = HALT;
                    CL_NOP:  final_c = 1'b1;
                    default: state_d = EXECUTE;
                endcase
            end
            EXECUTE: begin
                if (classe == CL_BRANCH) begin
                    final_c = 1'b1;
                    if (taken) next_pc = pc_q + $unsigned(desloc);
                end else if (classe == CL_LOAD || classe == CL_STORE) begin
                    state_d = MEMORY;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            MEMORY: begin
                mem_read_c  = (classe == CL_LOAD);
                mem_write_c = (classe == CL_STORE);
                if (classe == CL_LOAD) state_d = WRITEBACK;
                else                   final_c = 1'b1;
            end
            WRITEBACK: begin
                reg_write_c = 1'b1;
                final_c     = 1'b1;
            end
            HALT:    halted_c = 1'b1;
            default: state_d = HALT;
        endcase

        // Retire: commit the PC, count, and stop once the PC leaves instruction memory.
        if (final_c) begin
            pc_write_c = 1'b1;
            pc_d       = next_pc;
            cnt_d      = cnt_q + XLEN'(1);
            state_d    = (next_pc >= XLEN'(PC_LIMIT)) ? HALT : FETCH;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.estado      = 3'(state_q);
    assign bus.instr_count = cnt_q;
    assign bus.reg_write   = reg_write_c;
    assign bus.mem_read    = mem_read_c;
    assign bus.mem_write   = mem_write_c;
    assign bus.pc_write    = pc_write_c;
    assign bus.halted      = halted_c;

endmodule

// File: tb/tb_unidade_controle_pc.sv
// Bench for unidade_controle_pc: fetch-stage model feeding per-cycle expected traces.
module tb_unidade_controle_pc;

    localparam logic [2:0] S_F = 3'b000, S_D = 3'b001, S_E = 3'b010,
                           S_M = 3'b011, S_W = 3'b100, S_H = 3'b101;
    // Flag order: reg_write, mem_read, mem_write, pc_write, halted.
    localparam logic [4:0] F_0 = 5'b00000, F_RW = 5'b10000, F_MR = 5'b01000,
                           F_MW = 5'b00100, F_PW = 5'b00010, F_H = 5'b00001;
    localparam logic [31:0] NOP = 32'h0000007F, RTYPE = 32'h00000033,
                            LOAD = 32'h00000003, STORE = 32'h00000023;

    typedef struct packed {
        logic [2:0]  est;
        logic [31:0] pc;
        logic [4:0]  fl;
        logic [31:0] cnt;
    } obs_t;

    typedef struct {
        logic [31:0] instr;
        logic        az;
        logic [2:0]  est;
        logic [31:0] pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        az = 1'b0;
    logic [31:0] instr_q = '0;
    logic [31:0] imem [16];
    int          checks = 0;
    int          failures = 0;
    obs_t        tr[$];
    vec_t        vt[8];

    always #5 clk = ~clk;

    unidade_controle_pc_if bus ();
    assign bus.instrucao = instr_q;
    assign bus.alu_zero  = az;

    unidade_controle_pc #(.PC_LIMIT(11)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Fetch stage: latches the word at pc on the FETCH edge.
    always @(posedge clk)
        if (bus.estado == S_F) instr_q <= imem[bus.pc[3:0]];

    function automatic obs_t mk(logic [2:0] e, logic [31:0] p, logic [4:0] f, logic [31:0] c);
        obs_t o;
        o.est = e; o.pc = p; o.fl = f; o.cnt = c;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(bus.estado, bus.pc,
                  {bus.reg_write, bus.mem_read, bus.mem_write, bus.pc_write, bus.halted},
                  bus.instr_count);
    endfunction

    task automatic check_obs(input string name, input obs_t exp);
        obs_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got est=%b pc=%0h fl=%b cnt=%0d, want est=%b pc=%0h fl=%b cnt=%0d",
                     name, act.est, act.pc, act.fl, act.cnt, exp.est, exp.pc, exp.fl, exp.cnt);
        end
    endtask

    task automatic fill(input logic [31:0] w);
        for (int i = 0; i < 16; i++) imem[i] = w;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    // First row is checked right after reset release; then one row per cycle.
    task automatic run_trace(input string name);
        for (int i = 0; i < tr.size(); i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            check_obs($sformatf("%s[%0d]", name, i), tr[i]);
        end
        tr.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // R-type x3 then a zero word.
        fill('0);
        for (int i = 0; i < 3; i++) imem[i] = RTYPE;
        az = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            tr.push_back(mk(S_F, k, F_0, k));
            tr.push_back(mk(S_D, k, F_0, k));
            tr.push_back(mk(S_E, k, F_0, k));
            tr.push_back(mk(S_W, k, F_RW | F_PW, k));
        end
        tr.push_back(mk(S_F, 3, F_0, 3));
        tr.push_back(mk(S_D, 3, F_0, 3));
        tr.push_back(mk(S_H, 3, F_H, 3));
        tr.push_back(mk(S_H, 3, F_H, 3));
        run_trace("rtype");

        // LOAD then STORE.
        fill('0);
        imem[0] = LOAD;
        imem[1] = STORE;
        do_reset();
        tr.push_back(mk(S_F, 0, F_0, 0));
        tr.push_back(mk(S_D, 0, F_0, 0));
        tr.push_back(mk(S_E, 0, F_0, 0));
        tr.push_back(mk(S_M, 0, F_MR, 0));
        tr.push_back(mk(S_W, 0, F_RW | F_PW, 0));
        tr.push_back(mk(S_F, 1, F_0, 1));
        tr.push_back(mk(S_D, 1, F_0, 1));
        tr.push_back(mk(S_E, 1, F_0, 1));
        tr.push_back(mk(S_M, 1, F_MW | F_PW, 1));
        tr.push_back(mk(S_F, 2, F_0, 2));
        tr.push_back(mk(S_D, 2, F_0, 2));
        tr.push_back(mk(S_H, 2, F_H, 2));
        run_trace("ldst");

        // Branch at word 3 after three NOPs: {instr, alu_zero, final estado, final pc}.
        vt[0] = '{32'hFE000CE3, 1'b1, S_F, 32'd1};          // BEQ -8 taken
        vt[1] = '{32'hFE000CE3, 1'b0, S_F, 32'd4};          // BEQ -8 not taken
        vt[2] = '{32'h00001663, 1'b0, S_F, 32'd6};          // BNE +12 taken
        vt[3] = '{32'h00001663, 1'b1, S_F, 32'd4};          // BNE +12 not taken
        vt[4] = '{32'h00004663, 1'b1, S_F, 32'd4};          // funct3=100 never taken
        vt[5] = '{32'h00004663, 1'b0, S_F, 32'd4};
        vt[6] = '{32'h02000063, 1'b1, S_H, 32'd11};         // BEQ +32 lands on the limit
        vt[7] = '{32'hFE0008E3, 1'b1, S_H, 32'hFFFFFFFF};   // BEQ -16 wraps below zero
        for (int v = 0; v < 8; v++) begin
            fill('0);
            for (int i = 0; i < 3; i++) imem[i] = NOP;
            imem[3] = vt[v].instr;
            az = vt[v].az;
            do_reset();
            for (int k = 0; k < 3; k++) begin
                tr.push_back(mk(S_F, k, F_0, k));
                tr.push_back(mk(S_D, k, F_PW, k));
            end
            tr.push_back(mk(S_F, 3, F_0, 3));
            tr.push_back(mk(S_D, 3, F_0, 3));
            tr.push_back(mk(S_E, 3, F_PW, 3));
            tr.push_back(mk(vt[v].est, vt[v].pc, (vt[v].est == S_H) ? F_H : F_0, 4));
            run_trace($sformatf("br%0d", v));
        end
        az = 1'b0;

        // NOPs everywhere: stops at the PC limit and stays halted.
        fill(NOP);
        do_reset();
        for (int k = 0; k < 11; k++) begin
            tr.push_back(mk(S_F, k, F_0, k));
            tr.push_back(mk(S_D, k, F_PW, k));
        end
        for (int i = 0; i < 21; i++) tr.push_back(mk(S_H, 11, F_H, 11));
        run_trace("limit");

        // Async reset during MEMORY of a LOAD.
        fill('0);
        imem[0] = NOP;
        imem[1] = LOAD;
        do_reset();
        tr.push_back(mk(S_F, 0, F_0, 0));
        tr.push_back(mk(S_D, 0, F_PW, 0));
        tr.push_back(mk(S_F, 1, F_0, 1));
        tr.push_back(mk(S_D, 1, F_0, 1));
        tr.push_back(mk(S_E, 1, F_0, 1));
        tr.push_back(mk(S_M, 1, F_MR, 1));
        run_trace("pre_rst");
        #2 reset_n = 1'b0;
        #1 check_obs("async_rst", mk(S_F, 0, F_0, 0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        tr.push_back(mk(S_F, 0, F_0, 0));
        tr.push_back(mk(S_D, 0, F_PW, 0));
        tr.push_back(mk(S_F, 1, F_0, 1));
        tr.push_back(mk(S_D, 1, F_0, 1));
        run_trace("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
